// File: rtl/train_delay_stats_if.sv
`default_nettype none
// ============================================================================
// train_delay_stats_if: AXI-stream style record channel (master/slave views).
// Revision 1.0
// ============================================================================
interface train_delay_stats_if #(
  parameter int DATA_W = 160
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/train_delay_stats.sv
`default_nettype none
// ============================================================================
// train_delay_stats: per-train one-way latency statistics, one summary per train.
// Revision 1.0
// ============================================================================
module train_delay_stats #(
  parameter logic [15:0] TRAIN_LEN      = 16'd1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int          IN_WIDTH       = 160,
  parameter int          OUT_WIDTH      = 256
) (
  input wire                   clk,
  input wire                   reset,
  train_delay_stats_if.slave   s_axis,
  train_delay_stats_if.master  m_axis
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic [15:0] r_first_id,   w_first_id_nxt;
  logic [15:0] r_last_id,    w_last_id_nxt;
  logic [63:0] r_first_rx,   w_first_rx_nxt;
  logic [63:0] r_last_rx,    w_last_rx_nxt;
  logic [15:0] r_pkt_count,  w_pkt_count_nxt;
  logic [31:0] r_byte_count, w_byte_count_nxt;
  logic [31:0] r_min_lat,    w_min_lat_nxt;
  logic [31:0] r_max_lat,    w_max_lat_nxt;
  logic [63:0] r_sum_lat,    w_sum_lat_nxt;
  logic [31:0] r_timeout,    w_timeout_nxt;

  logic [OUT_WIDTH-1:0] r_summary;

  // Input record fields
  logic [IN_WIDTH-1:0] w_in;
  logic [15:0]         w_len;
  logic [15:0]         w_id;
  logic [63:0]         w_ts_tx;
  logic [63:0]         w_ts_rx;
  logic [63:0]         w_lat64;
  logic [31:0]         w_lat;
  logic [32:0]         w_byte_sum;
  logic [31:0]         w_byte_sat;

  logic w_ready;
  logic w_valid;
  logic w_accept;
  logic w_boundary;
  logic w_enter_emit;
  logic w_unused;

  assign w_in    = s_axis.tdata;
  assign w_len   = w_in[159:144];
  assign w_id    = w_in[143:128];
  assign w_ts_tx = w_in[127:64];
  assign w_ts_rx = w_in[63:0];

  assign w_unused = ^{s_axis.tstrb, s_axis.tlast};

  // Latencies that do not fit in 32 bits clamp to all-ones
  assign w_lat64 = w_ts_rx - w_ts_tx;
  assign w_lat   = (|w_lat64[63:32]) ? 32'hFFFF_FFFF : w_lat64[31:0];

  assign w_byte_sum = {1'b0, r_byte_count} + {17'd0, w_len};
  assign w_byte_sat = w_byte_sum[32] ? 32'hFFFF_FFFF : w_byte_sum[31:0];

  assign w_accept   = s_axis.tvalid & w_ready;
  assign w_boundary = (r_state == S_ACCUM) & s_axis.tvalid & ~w_ready;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_pkt_count_nxt == TRAIN_LEN) ? S_EMIT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_boundary) begin
          w_state_nxt = S_EMIT;
        end else if (w_accept) begin
          if (w_pkt_count_nxt == TRAIN_LEN) begin
            w_state_nxt = S_EMIT;
          end
        end else if (w_timeout_nxt == TIMEOUT_CYCLES) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (m_axis.tready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Output logic; ready never looks at m_axis.tready
  // ------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_ACCUM: w_ready = (w_id > r_last_id);
      S_EMIT:  w_valid = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  assign s_axis.tready = w_ready;
  assign m_axis.tvalid = w_valid;
  assign m_axis.tlast  = w_valid;
  assign m_axis.tstrb  = {(OUT_WIDTH/8){w_valid}};
  assign m_axis.tdata  = r_summary;

  // ------------------------------------------------------------------
  // Accumulator next values
  // ------------------------------------------------------------------
  always_comb begin
    w_first_id_nxt   = r_first_id;
    w_last_id_nxt    = r_last_id;
    w_first_rx_nxt   = r_first_rx;
    w_last_rx_nxt    = r_last_rx;
    w_pkt_count_nxt  = r_pkt_count;
    w_byte_count_nxt = r_byte_count;
    w_min_lat_nxt    = r_min_lat;
    w_max_lat_nxt    = r_max_lat;
    w_sum_lat_nxt    = r_sum_lat;
    w_timeout_nxt    = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_first_id_nxt   = w_id;
          w_last_id_nxt    = w_id;
          w_first_rx_nxt   = w_ts_rx;
          w_last_rx_nxt    = w_ts_rx;
          w_pkt_count_nxt  = 16'd1;
          w_byte_count_nxt = {16'd0, w_len};
          w_min_lat_nxt    = w_lat;
          w_max_lat_nxt    = w_lat;
          w_sum_lat_nxt    = {32'd0, w_lat};
          w_timeout_nxt    = 32'd0;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_last_id_nxt    = w_id;
          w_last_rx_nxt    = w_ts_rx;
          w_pkt_count_nxt  = r_pkt_count + 16'd1;
          w_byte_count_nxt = w_byte_sat;
          w_min_lat_nxt    = (w_lat < r_min_lat) ? w_lat : r_min_lat;
          w_max_lat_nxt    = (w_lat > r_max_lat) ? w_lat : r_max_lat;
          w_sum_lat_nxt    = r_sum_lat + {32'd0, w_lat};
          w_timeout_nxt    = 32'd0;
        end else if (!w_boundary) begin
          w_timeout_nxt    = r_timeout + 32'd1;
        end
      end
      S_EMIT: begin
        if (m_axis.tready) begin
          w_first_id_nxt   = 16'd0;
          w_last_id_nxt    = 16'd0;
          w_first_rx_nxt   = 64'd0;
          w_last_rx_nxt    = 64'd0;
          w_pkt_count_nxt  = 16'd0;
          w_byte_count_nxt = 32'd0;
          w_min_lat_nxt    = 32'd0;
          w_max_lat_nxt    = 32'd0;
          w_sum_lat_nxt    = 64'd0;
          w_timeout_nxt    = 32'd0;
        end
      end
      default: w_timeout_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first_id   <= 16'd0;
      r_last_id    <= 16'd0;
      r_first_rx   <= 64'd0;
      r_last_rx    <= 64'd0;
      r_pkt_count  <= 16'd0;
      r_byte_count <= 32'd0;
      r_min_lat    <= 32'd0;
      r_max_lat    <= 32'd0;
      r_sum_lat    <= 64'd0;
      r_timeout    <= 32'd0;
    end else begin
      r_first_id   <= w_first_id_nxt;
      r_last_id    <= w_last_id_nxt;
      r_first_rx   <= w_first_rx_nxt;
      r_last_rx    <= w_last_rx_nxt;
      r_pkt_count  <= w_pkt_count_nxt;
      r_byte_count <= w_byte_count_nxt;
      r_min_lat    <= w_min_lat_nxt;
      r_max_lat    <= w_max_lat_nxt;
      r_sum_lat    <= w_sum_lat_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Summary record, built from the values the train closes with
  // ------------------------------------------------------------------
  logic [17:0]          w_span;
  logic [17:0]          w_lost_raw;
  logic [15:0]          w_lost;
  logic [63:0]          w_duration;
  logic [OUT_WIDTH-1:0] w_summary;

  assign w_span     = {2'b00, w_last_id_nxt} - {2'b00, w_first_id_nxt} + 18'd1;
  assign w_lost_raw = w_span - {2'b00, w_pkt_count_nxt};
  assign w_lost     = w_lost_raw[17] ? 16'd0 :
                      (w_lost_raw[16] ? 16'hFFFF : w_lost_raw[15:0]);
  assign w_duration = w_last_rx_nxt - w_first_rx_nxt;

  assign w_summary = {w_pkt_count_nxt, w_lost, w_byte_count_nxt,
                      w_min_lat_nxt, w_max_lat_nxt, w_sum_lat_nxt, w_duration};

  assign w_enter_emit = (r_state != S_EMIT) && (w_state_nxt == S_EMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_summary <= '0;
    end else if (w_enter_emit) begin
      r_summary <= w_summary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_train_delay_stats.sv
`default_nettype none
// ============================================================================
// tb_train_delay_stats: randomized and directed checks against a queue model.
// Revision 1.0
// ============================================================================
module tb_train_delay_stats;

  localparam logic [15:0] TL = 16'd4;
  localparam logic [31:0] TO = 32'd20;

  logic clk = 1'b0;
  logic reset = 1'b1;

  train_delay_stats_if #(.DATA_W(160)) s_if ();
  train_delay_stats_if #(.DATA_W(256)) m_if ();

  train_delay_stats #(
    .TRAIN_LEN      (TL),
    .TIMEOUT_CYCLES (TO),
    .IN_WIDTH       (160),
    .OUT_WIDTH      (256)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: list of records in the open train
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] id;
    logic [15:0] len;
    logic [63:0] tx;
    logic [63:0] rx;
  } rec_t;

  rec_t           train_q[$];
  bit             emitting = 1'b0;
  logic [255:0]   exp_sum = '0;
  int             idle_cnt = 0;

  function automatic logic [31:0] lat_of(input logic [63:0] tx, input logic [63:0] rx);
    logic [63:0] d;
    d = rx - tx;
    return (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
  endfunction

  function automatic logic [255:0] summarize();
    logic [63:0] bytes;
    logic [63:0] sum;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] l;
    int          span;
    int          lost;
    bytes = 0; sum = 0; mn = 32'hFFFF_FFFF; mx = 0;
    foreach (train_q[i]) begin
      l = lat_of(train_q[i].tx, train_q[i].rx);
      bytes += 64'(train_q[i].len);
      sum   += 64'(l);
      if (l < mn) mn = l;
      if (l > mx) mx = l;
    end
    if (bytes > 64'hFFFF_FFFF) bytes = 64'hFFFF_FFFF;
    span = int'(train_q[train_q.size()-1].id) - int'(train_q[0].id) + 1;
    lost = span - train_q.size();
    if (lost < 0) lost = 0;
    if (lost > 65535) lost = 65535;
    return {16'(train_q.size()), 16'(lost), bytes[31:0], mn, mx, sum,
            64'(train_q[train_q.size()-1].rx - train_q[0].rx)};
  endfunction

  task automatic close_train();
    exp_sum  = summarize();
    emitting = 1'b1;
    train_q.delete();
    idle_cnt = 0;
  endtask

  // Compare process: outputs vs model each cycle, then advance the model
  bit   exp_rdy;
  rec_t cur;
  always @(negedge clk) begin
    if (reset) begin
      check("m_tvalid_in_reset", m_if.tvalid, 0);
      train_q.delete();
      emitting = 1'b0;
      idle_cnt = 0;
    end else begin
      cur.len = s_if.tdata[159:144];
      cur.id  = s_if.tdata[143:128];
      cur.tx  = s_if.tdata[127:64];
      cur.rx  = s_if.tdata[63:0];
      if (emitting)               exp_rdy = 1'b0;
      else if (train_q.size()==0) exp_rdy = 1'b1;
      else                        exp_rdy = (cur.id > train_q[train_q.size()-1].id);

      check("s_tready", s_if.tready, exp_rdy);
      check("m_tvalid", m_if.tvalid, emitting);
      check("m_tlast", m_if.tlast, emitting);
      check("m_tstrb", m_if.tstrb, {32{emitting}});
      if (emitting) check("m_tdata", m_if.tdata, exp_sum);

      if (emitting) begin
        if (m_if.tready) emitting = 1'b0;
      end else if (s_if.tvalid && !exp_rdy) begin
        close_train();
      end else if (s_if.tvalid) begin
        train_q.push_back(cur);
        idle_cnt = 0;
        if (train_q.size() == int'(TL)) close_train();
      end else if (train_q.size() != 0) begin
        idle_cnt++;
        if (idle_cnt == int'(TO)) close_train();
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (inputs change only at posedge + 2)
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] id, input logic [15:0] len,
                      input logic [63:0] tx, input logic [63:0] rx);
    bit ok;
    ok = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {len, id, tx, rx};
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_if.tready;
      step();
    end
    check("send_accepted", ok, 1);
    s_if.tvalid = 1'b0;
  endtask

  int n;
  task automatic wait_valid();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n = i + 1;
      if (m_if.tvalid) break;
    end
    check("wait_m_tvalid", m_if.tvalid, 1);
  endtask

  logic [255:0] held;
  int           beats;
  int           drv_id;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("reset_m_tvalid", m_if.tvalid, 0);
    check("reset_m_tdata", m_if.tdata, 0);
    check("reset_m_tstrb", m_if.tstrb, 0);
    check("reset_s_tready", s_if.tready, 1);
    step();

    // Nominal train
    for (int k = 1; k <= 4; k++)
      send(16'(k), 16'd100, 64'(1000*k), 64'(1000*k + 50 + k));
    wait_valid();
    check("nom_pkt",   m_if.tdata[255:240], 4);
    check("nom_lost",  m_if.tdata[239:224], 0);
    check("nom_bytes", m_if.tdata[223:192], 400);
    check("nom_min",   m_if.tdata[191:160], 51);
    check("nom_max",   m_if.tdata[159:128], 54);
    check("nom_sum",   m_if.tdata[127:64],  210);
    check("nom_dur",   m_if.tdata[63:0],    3003);
    step();

    // Loss and timeout: n counts the negedge right after the last accept too
    send(16'd1, 16'd64, 64'd0, 64'd10);
    send(16'd2, 16'd64, 64'd0, 64'd20);
    send(16'd5, 16'd64, 64'd0, 64'd50);
    wait_valid();
    check("timeout_cycles", n - 1, 20);
    check("loss_pkt",  m_if.tdata[255:240], 3);
    check("loss_lost", m_if.tdata[239:224], 2);
    step();

    // Boundary: id 0 after 7,8,9 closes the train and starts the next one
    m_if.tready = 1'b0;
    send(16'd7, 16'd10, 64'd100, 64'd200);
    send(16'd8, 16'd10, 64'd100, 64'd210);
    send(16'd9, 16'd10, 64'd100, 64'd220);
    s_if.tvalid = 1'b1;
    s_if.tdata  = {16'd10, 16'd0, 64'd100, 64'd230};
    @(negedge clk);
    check("boundary_s_tready", s_if.tready, 0);
    wait_valid();
    check("boundary_pkt",  m_if.tdata[255:240], 3);
    check("boundary_lost", m_if.tdata[239:224], 0);
    step();
    m_if.tready = 1'b1;
    send(16'd0, 16'd10, 64'd100, 64'd230);
    send(16'd1, 16'd10, 64'd100, 64'd240);
    send(16'd2, 16'd10, 64'd100, 64'd250);
    send(16'd3, 16'd10, 64'd100, 64'd260);
    wait_valid();
    check("next_train_pkt",  m_if.tdata[255:240], 4);
    check("next_train_lost", m_if.tdata[239:224], 0);
    check("next_train_dur",  m_if.tdata[63:0], 30);
    step();

    // Backpressure: 50 cycles held in EMIT with a record waiting upstream
    m_if.tready = 1'b0;
    for (int k = 10; k <= 13; k++)
      send(16'(k), 16'd20, 64'd0, 64'(k));
    wait_valid();
    held = m_if.tdata;
    step();
    s_if.tvalid = 1'b1;
    s_if.tdata  = {16'd20, 16'd100, 64'd0, 64'd5};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_m_tvalid", m_if.tvalid, 1);
      check("bp_m_tdata", m_if.tdata, held);
      check("bp_s_tready", s_if.tready, 0);
    end
    step();
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_if.tvalid && m_if.tready) beats++;
    end
    check("bp_beats", beats, 1);
    step();

    // Latency wrap and clamp
    send(16'd1, 16'd8, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5);
    send(16'd2, 16'd8, 64'd0, 64'h2_0000_0000);
    wait_valid();
    check("wrap_min", m_if.tdata[191:160], 15);
    check("clamp_max", m_if.tdata[159:128], 32'hFFFF_FFFF);
    check("clamp_sum", m_if.tdata[127:64], 64'h1_0000_000E);
    step();

    // Reset mid-train
    send(16'd1, 16'd50, 64'd0, 64'd100);
    send(16'd2, 16'd50, 64'd0, 64'd110);
    reset = 1'b1;
    #1;
    check("reset_mid_m_tvalid", m_if.tvalid, 0);
    step();
    reset = 1'b0;
    repeat (40) step();
    @(negedge clk);
    check("no_stale_summary", m_if.tvalid, 0);
    step();
    for (int k = 1; k <= 4; k++)
      send(16'(k + 20), 16'd50, 64'd0, 64'(k * 7));
    wait_valid();
    check("post_reset_pkt", m_if.tdata[255:240], 4);
    step();

    // Randomized traffic
    drv_id = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 300) < 25) begin
        s_if.tvalid = 1'b0;
      end else begin
        s_if.tvalid = ($urandom % 4) != 0;
      end
      if (($urandom % 10) == 0) drv_id = int'($urandom_range(0, 3));
      else                      drv_id = (drv_id + int'($urandom_range(0, 2))) % 65536;
      s_if.tdata[159:144] = 16'($urandom);
      s_if.tdata[143:128] = 16'(drv_id);
      s_if.tdata[127:64]  = {$urandom, $urandom};
      if (($urandom % 8) == 0) s_if.tdata[63:0] = {$urandom, $urandom};
      else s_if.tdata[63:0] = s_if.tdata[127:64] + 64'($urandom_range(0, 5000));
      s_if.tstrb  = 20'($urandom);
      s_if.tlast  = 1'($urandom);
      m_if.tready = ($urandom % 3) != 0;
      step();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
